// File: rtl/cook_timer.sv
// Keypad-entered MM:SS BCD cook timer that counts down at 1 Hz while the magnetron runs.
// Optional feature: define COOK_TIMER_ADD30_EN to add the add30 (+30 s) strobe input.
module cook_timer #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clearn,
    input  logic       load_digit,
    input  logic [3:0] digit,
    input  logic       mag_on,
`ifdef COOK_TIMER_ADD30_EN
    input  logic       add30,
`endif
    output logic       timer_done,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, SET, COUNT} state_t;

    state_t         state_q, nxt_state;
    logic [15:0]    time_q, nxt_time;
    logic [PW-1:0]  presc_q, nxt_presc;
    logic           count_en;

    // One-second BCD decrement; only ever applied to a nonzero time.
    function automatic logic [15:0] dec_bcd(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (t[7:4] != 4'd0) begin
                r[7:4] = t[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (t[11:8] != 4'd0) begin
                    r[11:8] = t[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

`ifdef COOK_TIMER_ADD30_EN
    // +30 s on the seconds-tens digit, carrying into minutes; saturates at 99:59.
    function automatic logic [15:0] add30_bcd(input logic [15:0] t);
        logic [15:0] r;
        logic [4:0]  st3;
        logic [4:0]  sub;
        r   = t;
        st3 = {1'b0, t[7:4]} + 5'd3;
        sub = st3 - 5'd6;
        if (st3 < 5'd6) begin
            r[7:4] = st3[3:0];
        end else if (t[15:8] == 8'h99) begin
            r = 16'h9959;
        end else begin
            r[7:4] = sub[3:0];
            if (t[11:8] == 4'd9) begin
                r[11:8]  = 4'd0;
                r[15:12] = t[15:12] + 4'd1;
            end else begin
                r[11:8] = t[11:8] + 4'd1;
            end
        end
        return r;
    endfunction
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            time_q     <= '0;
            presc_q    <= '0;
            timer_done <= 1'b1;
            running    <= 1'b0;
        end else begin
            state_q    <= nxt_state;
            time_q     <= nxt_time;
            presc_q    <= nxt_presc;
            timer_done <= (nxt_state == IDLE);
            running    <= (nxt_state == COUNT);
        end
    end

    // Counting follows mag_on directly so a resume picks up the held prescaler on the same edge.
    always_comb begin
        nxt_time  = time_q;
        nxt_presc = presc_q;
        count_en  = mag_on && (state_q != IDLE);
        if (!clearn) begin
            nxt_time  = '0;
            nxt_presc = '0;
        end else begin
            if (count_en) begin
                if (presc_q == PRESC_MAX) begin
                    nxt_presc = '0;
                    nxt_time  = dec_bcd(time_q);
                end else begin
                    nxt_presc = presc_q + PW'(1);
                end
            end else if (load_digit && !mag_on && (digit <= 4'd9)) begin
                nxt_time  = {time_q[11:0], digit};
                nxt_presc = '0;
            end
`ifdef COOK_TIMER_ADD30_EN
            if (add30)
                nxt_time = add30_bcd(nxt_time);
`endif
        end
        if (nxt_time == 16'h0000)
            nxt_state = IDLE;
        else if (mag_on)
            nxt_state = COUNT;
        else
            nxt_state = SET;
    end

    assign {min_tens, min_ones, sec_tens, sec_ones} = time_q;

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer: expected displays are queued with the stimulus and
// popped when the DUT output is sampled on the falling edge.
module tb_cook_timer;

    logic       clk = 1'b0;
    logic       reset, clearn, load_digit, mag_on;
    logic [3:0] digit;
    logic       timer_done, running;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
`ifdef COOK_TIMER_ADD30_EN
    logic       add30;
`endif

    cook_timer #(.TICKS_PER_SEC(4)) dut (
        .clk(clk), .reset(reset), .clearn(clearn), .load_digit(load_digit),
        .digit(digit), .mag_on(mag_on),
`ifdef COOK_TIMER_ADD30_EN
        .add30(add30),
`endif
        .timer_done(timer_done), .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [17:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [17:0] pk(int m, int s, bit d, bit r);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), d, r};
    endfunction

    task automatic run(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check();
        exp_t        e;
        logic [17:0] obs;
        obs = {min_tens, min_ones, sec_tens, sec_ones, timer_done, running};
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h (mmss/done/run) expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic exp_after(string tag, int n, logic [17:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
        run(n);
        check();
    endtask

    task automatic enter(logic [3:0] d);
        load_digit = 1'b1;
        digit      = d;
        run(1);
        load_digit = 1'b0;
    endtask

    task automatic clear();
        clearn = 1'b0;
        run(1);
        clearn = 1'b1;
    endtask

    initial begin
        reset = 1'b1; clearn = 1'b1; load_digit = 1'b0; mag_on = 1'b0; digit = 4'd0;
`ifdef COOK_TIMER_ADD30_EN
        add30 = 1'b0;
`endif
        run(2);
        exp_after("reset", 0, pk(0, 0, 1, 0));
        reset = 1'b0;

        mag_on = 1'b1;
        exp_after("idle_mag_on", 20, pk(0, 0, 1, 0));
        mag_on = 1'b0;

        enter(4'd1); exp_after("entry_1", 0, pk(0, 1, 0, 0));
        enter(4'd3); exp_after("entry_13", 0, pk(0, 13, 0, 0));
        enter(4'd0); exp_after("entry_130", 0, pk(1, 30, 0, 0));
        enter(4'd12); exp_after("entry_bad_digit", 0, pk(1, 30, 0, 0));
        clear();     exp_after("clear_set", 0, pk(0, 0, 1, 0));
        enter(4'd0); exp_after("entry_zero_idle", 0, pk(0, 0, 1, 0));

        enter(4'd2); exp_after("entry_2", 0, pk(0, 2, 0, 0));
        mag_on = 1'b1;
        exp_after("cnt2_pre", 3, pk(0, 2, 0, 1));
        exp_after("cnt2_1s", 1, pk(0, 1, 0, 1));
        exp_after("cnt2_done", 4, pk(0, 0, 1, 0));
        mag_on = 1'b0;

        enter(4'd1); enter(4'd0); enter(4'd0);
        exp_after("entry_100", 0, pk(1, 0, 0, 0));
        mag_on = 1'b1;
        exp_after("pause_pre", 2, pk(1, 0, 0, 1));
        mag_on = 1'b0;
        exp_after("pause_hold", 10, pk(1, 0, 0, 0));
        mag_on = 1'b1;
        exp_after("resume_1", 1, pk(1, 0, 0, 1));
        exp_after("resume_dec", 1, pk(0, 59, 0, 1));
        mag_on = 1'b0;
        clear();     exp_after("clear_paused", 0, pk(0, 0, 1, 0));

        enter(4'd9); enter(4'd0);
        exp_after("entry_90", 0, pk(0, 90, 0, 0));
        mag_on = 1'b1;
        for (int s = 89; s >= 0; s--)
            exp_after($sformatf("cnt90_%0d", s), 4, pk(0, s, s == 0, s != 0));
        mag_on = 1'b0;

        enter(4'd9); enter(4'd0);
        mag_on = 1'b1;
        run(6);
        clearn = 1'b0;
        exp_after("clear_mid_count", 1, pk(0, 0, 1, 0));
        clearn = 1'b1;
        exp_after("idle_after_clear", 4, pk(0, 0, 1, 0));
        mag_on = 1'b0;

        enter(4'd1); enter(4'd2); enter(4'd3); enter(4'd4); enter(4'd5);
        exp_after("entry_shift_out", 0, pk(23, 45, 0, 0));
        clear();

        enter(4'd1); enter(4'd0); enter(4'd0); enter(4'd0);
        exp_after("entry_1000", 0, pk(10, 0, 0, 0));
        mag_on = 1'b1;
        exp_after("borrow_0959", 4, pk(9, 59, 0, 1));
        mag_on = 1'b0;
        clear();

`ifdef COOK_TIMER_ADD30_EN
        enter(4'd4); enter(4'd5);
        add30 = 1'b1; run(1); add30 = 1'b0;
        exp_after("add30_0045", 0, pk(1, 15, 0, 0));
        clear();
        enter(4'd9); enter(4'd9); enter(4'd5); enter(4'd0);
        add30 = 1'b1; run(1); add30 = 1'b0;
        exp_after("add30_sat", 0, pk(99, 59, 0, 0));
        clear();
        add30 = 1'b1; run(1); add30 = 1'b0;
        exp_after("add30_idle", 0, pk(0, 30, 0, 0));
        clear();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
